// File: rtl/snake_pkg.sv
// Shared types and widths for the snake game: FSM state encoding, score width,
// and the apple coordinate widths used by the VGA/snake datapath.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_DIE     = 2'd2,
    ST_RESTART = 2'd3
  } state_e;

  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned APPLE_X_W = 6;
  localparam int unsigned APPLE_Y_W = 5;

endpackage

// File: rtl/move_tick_gen.sv
// Programmable move-tick divider: pulses once every `period` enabled cycles.
module move_tick_gen
  import snake_pkg::*;
#(
  parameter int unsigned DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // div+1 >= period is div >= period-1 without underflow; >= lets a shrinking
  // period catch up on the very next cycle instead of wrapping the counter.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      if (({1'b0, div_q} + (DIV_W + 1)'(1)) >= {1'b0, period}) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-flow controller: IDLE/PLAY/DIE/RESTART sequencing, speed-up on
// apples, score keeping, apple req/ack handshake and the death flash.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DIV_W            = 25,
  parameter int unsigned MOVE_PERIOD_INIT = 20_000_000,
  parameter int unsigned MIN_PERIOD       = 5_000_000,
  parameter int unsigned SPEED_STEP       = 1_000_000,
  parameter int unsigned FLASH_PERIOD     = 25_000_000,
  parameter int unsigned FLASH_TOGGLES    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_key,
  input  logic               hit_wall,
  input  logic               hit_body,
  input  logic               apple_eaten,
  input  logic               apple_ack,
  output logic [1:0]         game_status,
  output logic               move_tick,
  output logic               apple_req,
  output logic               snake_reset,
  output logic               blank,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned FLASH_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int unsigned TOG_W   = $clog2(FLASH_TOGGLES + 1);
  localparam logic [DIV_W:0] SHRINK_FLOOR = (DIV_W + 1)'(MIN_PERIOD + SPEED_STEP);

  state_e               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [DIV_W-1:0]     period_q, period_d;
  logic                 apple_req_q, apple_req_d;
  logic                 blank_q, blank_d;
  logic                 snake_reset_q, snake_reset_d;
  logic [FLASH_W-1:0]   flash_cnt_q, flash_cnt_d;
  logic [TOG_W-1:0]     tog_cnt_q, tog_cnt_d;
  logic                 collision;
  logic                 eat_ok;
  logic                 tick_en;
  logic                 tick_clr;

  assign collision = hit_wall | hit_body;
  assign eat_ok    = (state_q == ST_PLAY) && apple_eaten && !collision;
  assign tick_en   = (state_q == ST_PLAY) && !collision;
  assign tick_clr  = (state_q != ST_PLAY);

  move_tick_gen #(.DIV_W(DIV_W)) u_move_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (tick_en),
    .clr    (tick_clr),
    .period (period_q),
    .tick   (move_tick)
  );

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    period_d    = period_q;
    blank_d     = blank_q;
    flash_cnt_d = flash_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    // A fresh apple keeps the request up even if an ack lands the same cycle.
    apple_req_d = (apple_req_q & ~apple_ack) | eat_ok;

    case (state_q)
      ST_IDLE: begin
        if (start_key) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (collision) begin
          state_d = ST_DIE;
        end else if (apple_eaten) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          if ({1'b0, period_q} >= SHRINK_FLOOR) period_d = period_q - DIV_W'(SPEED_STEP);
          else                                  period_d = DIV_W'(MIN_PERIOD);
        end
      end
      ST_DIE: begin
        if (flash_cnt_q == FLASH_W'(FLASH_PERIOD - 1)) begin
          flash_cnt_d = '0;
          blank_d     = ~blank_q;
          tog_cnt_d   = tog_cnt_q + TOG_W'(1);
          if (tog_cnt_q == TOG_W'(FLASH_TOGGLES - 1)) state_d = ST_RESTART;
        end else begin
          flash_cnt_d = flash_cnt_q + FLASH_W'(1);
        end
      end
      ST_RESTART: begin
        state_d     = ST_IDLE;
        score_d     = '0;
        period_d    = DIV_W'(MOVE_PERIOD_INIT);
        apple_req_d = 1'b0;
        blank_d     = 1'b0;
        flash_cnt_d = '0;
        tog_cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    snake_reset_d = (state_d == ST_RESTART);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      score_q       <= '0;
      period_q      <= DIV_W'(MOVE_PERIOD_INIT);
      apple_req_q   <= 1'b0;
      blank_q       <= 1'b0;
      snake_reset_q <= 1'b0;
      flash_cnt_q   <= '0;
      tog_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      period_q      <= period_d;
      apple_req_q   <= apple_req_d;
      blank_q       <= blank_d;
      snake_reset_q <= snake_reset_d;
      flash_cnt_q   <= flash_cnt_d;
      tog_cnt_q     <= tog_cnt_d;
    end
  end

  assign game_status = state_q;
  assign apple_req   = apple_req_q;
  assign blank       = blank_q;
  assign snake_reset = snake_reset_q;
  assign score       = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed vector table, corner-case sequences and
// a randomized run compared against a cycle-level behavioural game model.
module tb_snake_game_ctrl;

  localparam int unsigned INIT = 10;
  localparam int unsigned MINP = 4;
  localparam int unsigned STEP = 2;
  localparam int unsigned FP   = 3;
  localparam int unsigned FT   = 4;

  logic       clk = 1'b0;
  logic       rst, start_key, hit_wall, hit_body, apple_eaten, apple_ack;
  logic [1:0] game_status;
  logic       move_tick, apple_req, snake_reset, blank;
  logic [7:0] score;

  int errors = 0;
  int checks = 0;

  // behavioural model: state as 0..3, "since" = play cycles since last tick,
  // "die" = cycles spent in DIE
  int m_state, m_score, m_period, m_since, m_die;
  int m_tick, m_req, m_blank, m_srst;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .DIV_W(25), .MOVE_PERIOD_INIT(INIT), .MIN_PERIOD(MINP),
    .SPEED_STEP(STEP), .FLASH_PERIOD(FP), .FLASH_TOGGLES(FT)
  ) dut (
    .clk(clk), .rst(rst), .start_key(start_key), .hit_wall(hit_wall),
    .hit_body(hit_body), .apple_eaten(apple_eaten), .apple_ack(apple_ack),
    .game_status(game_status), .move_tick(move_tick), .apple_req(apple_req),
    .snake_reset(snake_reset), .blank(blank), .score(score)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int coll;
    if (!rst) begin
      m_state = 0; m_score = 0; m_period = INIT; m_since = 0; m_die = 0;
      m_tick = 0; m_req = 0; m_blank = 0; m_srst = 0;
      return;
    end
    coll   = int'(hit_wall | hit_body);
    m_tick = 0;
    case (m_state)
      0: if (start_key) begin m_state = 1; m_since = 0; end
      1: begin
        if (coll != 0) begin
          m_state = 2; m_die = 0;
          m_req = m_req & int'(!apple_ack);
        end else begin
          m_since++;
          if (m_since >= m_period) begin m_tick = 1; m_since = 0; end
          m_req = m_req & int'(!apple_ack);
          if (apple_eaten) begin
            m_score  = (m_score < 255) ? m_score + 1 : 255;
            m_period = (m_period - int'(STEP) >= int'(MINP)) ? m_period - int'(STEP) : int'(MINP);
            m_req    = 1;
          end
        end
      end
      2: begin
        m_req = m_req & int'(!apple_ack);
        m_die++;
        m_blank = (m_die / FP) % 2;
        if (m_die == FP * FT) m_state = 3;
      end
      default: begin
        m_state = 0; m_score = 0; m_period = INIT; m_req = 0;
        m_blank = 0; m_since = 0; m_die = 0;
      end
    endcase
    m_srst = int'(m_state == 3);
  endtask

  task automatic cycle(input logic r, s, w, b, e, a);
    rst = r; start_key = s; hit_wall = w; hit_body = b; apple_eaten = e; apple_ack = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_status"}, int'(game_status), m_state);
    chk({tag, "_tick"},   int'(move_tick),   m_tick);
    chk({tag, "_req"},    int'(apple_req),   m_req);
    chk({tag, "_srst"},   int'(snake_reset), m_srst);
    chk({tag, "_blank"},  int'(blank),       m_blank);
    chk({tag, "_score"},  int'(score),       m_score);
  endtask

  task automatic step(input string tag, input logic r, s, w, b, e, a);
    cycle(r, s, w, b, e, a);
    check_model(tag);
  endtask

  typedef struct {
    logic rst_n, start, wall, body, eat, ack;
    int   st, tick, req, srst, blnk, scr;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int   gaps[$];
    int   exp_gaps[4];
    int   last, eats, ack_cd, toggles, srst_cycles, prev_blank;
    bit   eat_next, done;
    logic e, a;

    vecs[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0,0,0,0,0,0};
    vecs[1] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1,0,0,0,0,0};
    vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1,0,0,0,0,0};
    vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 1,0,1,0,0,1};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1,0,0,0,0,1};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2,0,0,0,0,1};
    vecs[6] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2,0,0,0,0,1};
    vecs[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2,0,0,0,0,1};
    vecs[8] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2,0,0,0,1,1};
    exp_gaps = '{8, 6, 4, 4};

    rst = 1'b0; start_key = 1'b0; hit_wall = 1'b0; hit_body = 1'b0;
    apple_eaten = 1'b0; apple_ack = 1'b0;

    // directed table: reset, start, eat/ack, collision beats apple, DIE flash
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].rst_n, vecs[i].start, vecs[i].wall, vecs[i].body, vecs[i].eat, vecs[i].ack);
      chk($sformatf("vec%0d_status", i), int'(game_status), vecs[i].st);
      chk($sformatf("vec%0d_tick", i),   int'(move_tick),   vecs[i].tick);
      chk($sformatf("vec%0d_req", i),    int'(apple_req),   vecs[i].req);
      chk($sformatf("vec%0d_srst", i),   int'(snake_reset), vecs[i].srst);
      chk($sformatf("vec%0d_blank", i),  int'(blank),       vecs[i].blnk);
      chk($sformatf("vec%0d_score", i),  int'(score),       vecs[i].scr);
    end

    // first tick exactly 10 cycles into PLAY, then every 10
    step("t1_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t1_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    last = -1; eats = 0;
    for (int k = 1; k <= 25; k++) begin
      step("t1_play", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (move_tick) begin
        if (eats == 0) chk("t1_first_tick", k, 10);
        else if (eats == 1) chk("t1_second_tick", k, 20);
        eats++;
      end
    end
    chk("t1_tick_count", eats, 2);

    // apple right after each tick, acked 2 cycles later: spacing 8,6,4,4
    last = -1; eats = 0; ack_cd = 0; eat_next = 1'b0;
    for (int c = 0; c < 120 && gaps.size() < 4; c++) begin
      e = eat_next; eat_next = 1'b0;
      a = (ack_cd == 1);
      if (ack_cd > 0) ack_cd--;
      if (e) ack_cd = 2;
      step("t2", 1'b1, 1'b0, 1'b0, 1'b0, e, a);
      if (move_tick) begin
        if (last >= 0) gaps.push_back(c - last);
        last = c;
        if (eats < 4) begin eat_next = 1'b1; eats++; end
      end
    end
    chk("t2_gap_count", gaps.size(), 4);
    for (int i = 0; i < 4 && i < gaps.size(); i++) chk($sformatf("t2_gap%0d", i), gaps[i], exp_gaps[i]);
    chk("t2_score", int'(score), 4);

    // death flash: 4 toggles, one-cycle snake_reset, then clean IDLE
    step("t4_hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    toggles = 0; srst_cycles = 0; prev_blank = int'(blank); done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step("t4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (int'(blank) != prev_blank) toggles++;
      prev_blank = int'(blank);
      if (snake_reset) srst_cycles++;
      if (srst_cycles > 0 && game_status == 2'd0) done = 1'b1;
    end
    chk("t4_done", int'(done), 1);
    chk("t4_toggles", toggles, int'(FT));
    chk("t4_srst_cycles", srst_cycles, 1);
    chk("t4_idle_score", int'(score), 0);
    chk("t4_idle_blank", int'(blank), 0);

    // two apples before any ack, then saturation over 256 apples
    step("t5_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t5_eat1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("t5_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t5_eat2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_req_held", int'(apple_req), 1);
    chk("t5_score2", int'(score), 2);
    step("t5_ack", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_req_clear", int'(apple_req), 0);
    for (int c = 0; c < 256; c++)
      step("t5_sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, logic'(c % 7 == 3));
    chk("t5_saturated", int'(score), 255);

    // reset mid-PLAY with a pending request, then start_key ignored in DIE
    step("t6_eat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_req_pending", int'(apple_req), 1);
    step("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_status", int'(game_status), 0);
    chk("t6_rst_req", int'(apple_req), 0);
    chk("t6_rst_score", int'(score), 0);
    step("t6_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t6_wall", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step("t6_die_start", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_die_hold", int'(game_status), 2);

    // randomized play against the model
    step("rnd_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      step("rnd",
           logic'($urandom_range(199, 0) != 0),
           logic'($urandom_range(19, 0) == 0),
           logic'($urandom_range(59, 0) == 0),
           logic'($urandom_range(59, 0) == 0),
           logic'($urandom_range(7, 0) == 0),
           logic'($urandom_range(3, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
